conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
Single-channel convolution sequencer for the MSDAP datapath; one instance each drives the left and the right channel.
- On each new input sample it walks the rj memory, the coefficient memory and the circular data memory.
- It issues add/sub and shift controls to the channel's adder/shift_accumulator pair, computing y(n) = (...((u1)/2 + u2)/2 ... + u16)/2.
- It signals completion to the PISO stage with a one-cycle done pulse.

Parameters:
NUM_RJ, 16, number of rj partitions (u_j terms)
COEFF_DEPTH, 512, coefficient memory depth; hard cap on total terms per sample
DATA_AW, 8, data memory address width (circular buffer of 2^DATA_AW samples)

Ports:
Sclk  in  1  system clock; all logic rising-edge
Reset_n  in  1  asynchronous active-low reset
Clear  in  1  synchronous abort/clear (from main_controller)
start  in  1  one-cycle pulse: new sample written at cur_addr
cur_addr  in  DATA_AW  data memory address of newest sample x(n)
valid_cnt  in  DATA_AW+1  samples stored since Clear, saturating at 2^DATA_AW
flag_zero  in  1  data memory holds only zeros (used by optional feature)
rj_en / rj_addr  out  1 / 4  rj memory read strobe / address
rj_data  in  16  rj memory read data; term count in [8:0]
coeff_en / coeff_addr  out  1 / 9  coefficient read strobe / address
coeff_data  in  16  bit8 = sign (1 = subtract), bits7:0 = delay k
data_en / data_addr  out  1 / DATA_AW  data memory read strobe / address
addsub  out  1  0 = add, 1 = subtract
adder_en, load, shift_en, acc_clear  out  1 each  accumulator controls
busy  out  1  computation in progress
done  out  1  one-cycle pulse: accumulator holds y(n)
overrun  out  1  sticky: start received while busy; cleared by Clear
coeff_ovf  out  1  sticky: rj counts exceed COEFF_DEPTH; cleared by Clear

Behaviour:
- Reset: all outputs 0; state IDLE; coefficient pointer 0; j 0.
- Memory read latency is 1 cycle: data is valid in the cycle after the strobe.
- IDLE --start--> CLR. CLR asserts acc_clear for 1 cycle, sets cp=0 and j=0, then -> RJ_RD.
- RJ_RD: rj_en=1, rj_addr=j. RJ_WAIT: latch cnt=rj_data[8:0]. If cnt=0 -> SHIFT, else -> CO_RD.
- CO_RD: coeff_en=1, coeff_addr=cp.
- CO_WAIT: latch sign and k; cp+=1; cnt-=1.
  - If k >= valid_cnt the term is zero: no data read -> TERM_END.
  - Otherwise data_en=1, data_addr=(cur_addr-k) mod 2^DATA_AW, computed with DATA_AW-bit wrap -> ACC.
- ACC: adder_en=1, load=1, addsub=sign -> TERM_END.
- TERM_END (0-cycle decision, merged into the previous state): cnt>0 -> CO_RD, else -> SHIFT.
- SHIFT: shift_en=1 for 1 cycle; j+=1. j=NUM_RJ -> DONE, else -> RJ_RD.
- DONE: done=1 for 1 cycle -> IDLE. busy=1 in every state except IDLE.
- Cost: 3 cycles per used term, 2 per skipped term, 2 per rj fetch, 1 per shift, plus CLR and DONE.
- Coefficient cap: if cp reaches COEFF_DEPTH while cnt>0:
  - set coeff_ovf;
  - remaining terms of all j are treated as zero;
  - rj fetches and shifts still run, so done still fires.
- start while busy: ignored, overrun set. start together with Clear: Clear wins.
- Clear in any state: next cycle IDLE; strobes and controls 0; acc_clear=1 for that cycle; sticky flags cleared; no done pulse.
- Reset_n low mid-operation: immediate return to reset values.
- Only one of load and shift_en is ever asserted in a given cycle.

Optional Feature:
Macro CONV_ZERO_SKIP_EN.
- Defined: if flag_zero=1 when start arrives, go CLR -> DONE. The accumulator stays 0 and done pulses 2 cycles after start with no memory reads.
- Undefined: flag_zero is ignored and the full sequence runs; the result is still 0, at full cycle cost.

Decomposition:
- msdap_pkg holds:
  - state enum (IDLE, CLR, RJ_RD, RJ_WAIT, CO_RD, CO_WAIT, ACC, SHIFT, DONE);
  - constants NUM_RJ, COEFF_DEPTH, COEFF_SIGN_BIT=8, COEFF_K_MSB=7, RJ_CNT_W=9.
- One sub-module, conv_addr_gen: combinational wrap-around data address plus the k >= valid_cnt validity compare. It is shared by both channel instances' test benches.

Test Plan:
- rj all 0, start: 16 SHIFT pulses, no coeff/data reads, done at cycle 1+16*3+1 after CLR, acc_clear once.
- rj[0]=1, coeff[0]=0x000 (k=0, add), cur_addr=0x05, valid_cnt=6: data_addr=0x05, load with addsub=0, then 16 shifts, done.
- coeff[0]=0x103 (subtract, k=3), cur_addr=0x01, valid_cnt=256: data_addr=0xFE (wrap), addsub=1.
- k=10, valid_cnt=4: no data_en, no load, term takes 2 cycles.
- rj sum=520: coeff_ovf=1 after cp=512, done still pulses. Second start while busy: overrun=1. Clear mid-ACC: IDLE next cycle, no done, flags 0.
- With CONV_ZERO_SKIP_EN, flag_zero=1, start: done 2 cycles later, zero rj/coeff/data strobes. Without the macro: full sequence runs.

Source files
------------

// File: rtl/msdap_pkg.sv
// Shared constants and sequencer state encoding for the MSDAP convolution datapath.
package msdap_pkg;

  localparam int NUM_RJ         = 16;
  localparam int COEFF_DEPTH    = 512;
  localparam int COEFF_SIGN_BIT = 8;
  localparam int COEFF_K_MSB    = 7;
  localparam int RJ_CNT_W       = 9;
  localparam int RJ_AW          = 4;
  localparam int COEFF_AW       = 9;
  // One bit wider than the coefficient address so the pointer can reach COEFF_DEPTH itself
  localparam int CP_W           = 10;
  localparam int J_W            = 5;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CLR     = 4'd1,
    RJ_RD   = 4'd2,
    RJ_WAIT = 4'd3,
    CO_RD   = 4'd4,
    CO_WAIT = 4'd5,
    ACC     = 4'd6,
    SHIFT   = 4'd7,
    DONE    = 4'd8
  } seqState_e;

  function automatic logic [RJ_CNT_W-1:0] rjCount(input logic [15:0] rjWord);
    return rjWord[RJ_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Memory read ports and accumulator controls between one conv_sequencer and its channel.
interface conv_sequencer_if #(parameter int DATA_AW = 8);
  import msdap_pkg::*;

  logic                rj_en;
  logic [RJ_AW-1:0]    rj_addr;
  logic [15:0]         rj_data;
  logic                coeff_en;
  logic [COEFF_AW-1:0] coeff_addr;
  logic [15:0]         coeff_data;
  logic                data_en;
  logic [DATA_AW-1:0]  data_addr;
  logic                addsub;
  logic                adder_en;
  logic                load;
  logic                shift_en;
  logic                acc_clear;

  modport master (
    output rj_en, rj_addr, coeff_en, coeff_addr, data_en, data_addr,
    output addsub, adder_en, load, shift_en, acc_clear,
    input  rj_data, coeff_data
  );

  modport slave (
    input  rj_en, rj_addr, coeff_en, coeff_addr, data_en, data_addr,
    input  addsub, adder_en, load, shift_en, acc_clear,
    output rj_data, coeff_data
  );

endinterface

// File: rtl/conv_addr_gen.sv
// Circular data-memory address (newest sample minus delay k) and term validity check.
// Assumes DATA_AW >= 8 so every delay k is representable.
module conv_addr_gen
  import msdap_pkg::*;
#(
  parameter int DATA_AW = 8
) (
  input  logic [DATA_AW-1:0]   curAddr,
  input  logic [COEFF_K_MSB:0] delayK,
  input  logic [DATA_AW:0]     validCnt,
  output logic [DATA_AW-1:0]   dataAddr,
  output logic                 termValid
);

  logic [DATA_AW:0] kExt_s;

  // Wrap-around subtraction and the "sample exists yet" compare
  always_comb begin
    kExt_s    = (DATA_AW+1)'(delayK);
    dataAddr  = curAddr - kExt_s[DATA_AW-1:0];
    termValid = (kExt_s < validCnt);
  end

endmodule

// File: rtl/conv_sequencer.sv
// Per-channel convolution sequencer: walks rj, coefficient and data memories and drives the
// adder/shift accumulator. Optional macro CONV_ZERO_SKIP_EN short-circuits all-zero history.
module conv_sequencer
  import msdap_pkg::*;
#(
  parameter int DATA_AW = 8
) (
  input  logic               Sclk,
  input  logic               Reset_n,
  input  logic               Clear,
  input  logic               start,
  input  logic [DATA_AW-1:0] cur_addr,
  input  logic [DATA_AW:0]   valid_cnt,
  input  logic               flag_zero,
  conv_sequencer_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic               coeff_ovf
);

  seqState_e             curState_r;
  seqState_e             nextState_s;
  seqState_e             endState_s;
  logic [CP_W-1:0]       coeffPtr_r;
  logic [CP_W-1:0]       cpAfter_s;
  logic [J_W-1:0]        jIdx_r;
  logic [RJ_CNT_W-1:0]   termCnt_r;
  logic [RJ_CNT_W-1:0]   remCnt_s;
  logic                  sign_r;
  logic                  zeroSkip_r;
  logic                  zeroReq_s;
  logic                  overrun_r;
  logic                  coeffOvf_r;
  logic                  capHit_s;
  logic                  setOvf_s;
  logic [DATA_AW-1:0]    genAddr_s;
  logic                  termValid_s;
  logic                  unusedBits_s;

`ifdef CONV_ZERO_SKIP_EN
  assign zeroReq_s    = flag_zero;
  assign unusedBits_s = ^{bus.rj_data[15:RJ_CNT_W], bus.coeff_data[15:COEFF_SIGN_BIT+1]};
`else
  assign zeroReq_s    = 1'b0;
  assign unusedBits_s = ^{bus.rj_data[15:RJ_CNT_W], bus.coeff_data[15:COEFF_SIGN_BIT+1], flag_zero};
`endif

  conv_addr_gen #(.DATA_AW(DATA_AW)) u_addr_gen (
    .curAddr   (cur_addr),
    .delayK    (bus.coeff_data[COEFF_K_MSB:0]),
    .validCnt  (valid_cnt),
    .dataAddr  (genAddr_s),
    .termValid (termValid_s)
  );

  assign busy      = (curState_r != IDLE);
  assign overrun   = overrun_r;
  assign coeff_ovf = coeffOvf_r;

  // Remaining-term and pointer view used by the shared end-of-term decision
  always_comb begin
    case (curState_r)
      RJ_WAIT: remCnt_s = rjCount(bus.rj_data);
      CO_WAIT: remCnt_s = termCnt_r - RJ_CNT_W'(1);
      default: remCnt_s = termCnt_r;
    endcase
    if (curState_r == CO_WAIT) begin
      cpAfter_s = coeffPtr_r + CP_W'(1);
    end else begin
      cpAfter_s = coeffPtr_r;
    end
    // Once the coefficient memory is exhausted, outstanding terms count as zero and are skipped
    capHit_s = (remCnt_s != RJ_CNT_W'(0)) && (cpAfter_s == CP_W'(COEFF_DEPTH));
    if ((remCnt_s == RJ_CNT_W'(0)) || capHit_s) begin
      endState_s = SHIFT;
    end else begin
      endState_s = CO_RD;
    end
  end

  // Next-state and strobe decode; Clear overrides every state
  always_comb begin
    nextState_s    = curState_r;
    setOvf_s       = 1'b0;
    done           = 1'b0;
    bus.rj_en      = 1'b0;
    bus.rj_addr    = '0;
    bus.coeff_en   = 1'b0;
    bus.coeff_addr = '0;
    bus.data_en    = 1'b0;
    bus.data_addr  = '0;
    bus.addsub     = 1'b0;
    bus.adder_en   = 1'b0;
    bus.load       = 1'b0;
    bus.shift_en   = 1'b0;
    bus.acc_clear  = 1'b0;
    if (Clear) begin
      nextState_s   = IDLE;
      bus.acc_clear = 1'b1;
    end else begin
      case (curState_r)
        IDLE: begin
          if (start) begin
            nextState_s = CLR;
          end else begin
            nextState_s = IDLE;
          end
        end
        CLR: begin
          bus.acc_clear = 1'b1;
          if (zeroSkip_r) begin
            nextState_s = DONE;
          end else begin
            nextState_s = RJ_RD;
          end
        end
        RJ_RD: begin
          bus.rj_en   = 1'b1;
          bus.rj_addr = jIdx_r[RJ_AW-1:0];
          nextState_s = RJ_WAIT;
        end
        RJ_WAIT: begin
          setOvf_s    = capHit_s;
          nextState_s = endState_s;
        end
        CO_RD: begin
          bus.coeff_en   = 1'b1;
          bus.coeff_addr = coeffPtr_r[COEFF_AW-1:0];
          nextState_s    = CO_WAIT;
        end
        CO_WAIT: begin
          if (termValid_s) begin
            bus.data_en   = 1'b1;
            bus.data_addr = genAddr_s;
            nextState_s   = ACC;
          end else begin
            setOvf_s    = capHit_s;
            nextState_s = endState_s;
          end
        end
        ACC: begin
          bus.adder_en = 1'b1;
          bus.load     = 1'b1;
          bus.addsub   = sign_r;
          setOvf_s     = capHit_s;
          nextState_s  = endState_s;
        end
        SHIFT: begin
          bus.shift_en = 1'b1;
          if (jIdx_r == J_W'(NUM_RJ - 1)) begin
            nextState_s = DONE;
          end else begin
            nextState_s = RJ_RD;
          end
        end
        DONE: begin
          done        = 1'b1;
          nextState_s = IDLE;
        end
        default: begin
          nextState_s = IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      curState_r <= IDLE;
    end else begin
      curState_r <= nextState_s;
    end
  end

  // Pointers, term counter, latched sign and sticky status flags
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      coeffPtr_r <= '0;
      jIdx_r     <= '0;
      termCnt_r  <= '0;
      sign_r     <= 1'b0;
      zeroSkip_r <= 1'b0;
      overrun_r  <= 1'b0;
      coeffOvf_r <= 1'b0;
    end else if (Clear) begin
      coeffPtr_r <= '0;
      jIdx_r     <= '0;
      termCnt_r  <= '0;
      sign_r     <= 1'b0;
      zeroSkip_r <= 1'b0;
      overrun_r  <= 1'b0;
      coeffOvf_r <= 1'b0;
    end else begin
      if (start && (curState_r != IDLE)) begin
        overrun_r <= 1'b1;
      end
      if (setOvf_s) begin
        coeffOvf_r <= 1'b1;
      end
      case (curState_r)
        IDLE: begin
          if (start) begin
            zeroSkip_r <= zeroReq_s;
          end
        end
        CLR: begin
          coeffPtr_r <= '0;
          jIdx_r     <= '0;
        end
        RJ_WAIT: begin
          termCnt_r <= remCnt_s;
        end
        CO_WAIT: begin
          sign_r     <= bus.coeff_data[COEFF_SIGN_BIT];
          coeffPtr_r <= cpAfter_s;
          termCnt_r  <= remCnt_s;
        end
        SHIFT: begin
          jIdx_r <= jIdx_r + J_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: memory and accumulator responders plus an arithmetic
// reference of y(n), cycle cost and strobe counts.
`timescale 1ns/1ps
module tb_conv_sequencer;

  logic       Sclk = 1'b0;
  logic       Reset_n, Clear, start, flag_zero;
  logic [7:0] cur_addr;
  logic [8:0] valid_cnt;
  logic       busy, done, overrun, coeff_ovf;

  conv_sequencer_if #(.DATA_AW(8)) bus();

  conv_sequencer #(.DATA_AW(8)) dut (
    .Sclk(Sclk), .Reset_n(Reset_n), .Clear(Clear), .start(start),
    .cur_addr(cur_addr), .valid_cnt(valid_cnt), .flag_zero(flag_zero),
    .bus(bus), .busy(busy), .done(done), .overrun(overrun), .coeff_ovf(coeff_ovf)
  );

  always #5 Sclk = ~Sclk;

  logic [15:0]        rjMem [16];
  logic [15:0]        coeffMem [512];
  logic signed [15:0] dataMem [256];
  logic signed [15:0] dataQ = 16'sd0;
  longint             acc = 0;

  int nTests = 0;
  int nFail  = 0;
  int rjCnt = 0, coCnt = 0, daCnt = 0, ldCnt = 0, shCnt = 0, clrCnt = 0, dnCnt = 0, bothCnt = 0;
  int lastAddr = -1, lastSign = -1;

  int     expL, expRj, expCo, expData, expShift, expAddr, expSign;
  longint expY;
  bit     expOvf;

  // One-cycle-latency memories
  always @(posedge Sclk) begin
    if (bus.rj_en)    bus.rj_data    <= rjMem[bus.rj_addr];
    if (bus.coeff_en) bus.coeff_data <= coeffMem[bus.coeff_addr];
    if (bus.data_en)  dataQ          <= dataMem[bus.data_addr];
  end

  // Adder / shift accumulator driven by the sequencer controls
  always @(posedge Sclk) begin
    if (bus.acc_clear) acc <= 0;
    else if (bus.load && bus.adder_en) acc <= bus.addsub ? acc - longint'(dataQ) : acc + longint'(dataQ);
    else if (bus.shift_en) acc <= acc >>> 1;
  end

  // Strobe counters
  always @(posedge Sclk) begin
    if (bus.rj_en)     rjCnt  <= rjCnt + 1;
    if (bus.coeff_en)  coCnt  <= coCnt + 1;
    if (bus.data_en)   begin daCnt <= daCnt + 1; lastAddr <= int'(bus.data_addr); end
    if (bus.load)      begin ldCnt <= ldCnt + 1; lastSign <= int'(bus.addsub); end
    if (bus.shift_en)  shCnt  <= shCnt + 1;
    if (bus.acc_clear) clrCnt <= clrCnt + 1;
    if (done)          dnCnt  <= dnCnt + 1;
    if (bus.load && bus.shift_en) bothCnt <= bothCnt + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: u_j = sum of +/- x(n-k) over valid terms, y = (y + u_j)/2 per partition (floor)
  task automatic refModel(input int ca, input int vc, input bit fz);
    int     cp;
    longint y, u;
    bit     skip;
`ifdef CONV_ZERO_SKIP_EN
    skip = fz;
`else
    skip = fz & 1'b0;
`endif
    expL = 1; expY = 0; expRj = 0; expCo = 0; expData = 0; expShift = 0;
    expOvf = 1'b0; expAddr = -1; expSign = -1;
    if (!skip) begin
      cp = 0; y = 0;
      for (int j = 0; j < 16; j++) begin
        int cnt;
        cnt = int'(rjMem[j][8:0]);
        u = 0;
        expL += 3; expRj++; expShift++;
        for (int t = 0; t < cnt; t++) begin
          int k;
          if (cp == 512) begin expOvf = 1'b1; break; end
          k = int'(coeffMem[cp][7:0]);
          expCo++;
          if (k >= vc) begin
            expL += 2;
          end else begin
            int idx;
            idx = ((ca - k) % 256 + 256) % 256;
            expL += 3; expData++; expAddr = idx; expSign = int'(coeffMem[cp][8]);
            u += coeffMem[cp][8] ? -longint'(dataMem[idx]) : longint'(dataMem[idx]);
          end
          cp++;
        end
        y = (y + u) >>> 1;
      end
      expY = y;
    end
  endtask

  task automatic doConv(input string tag, input logic [7:0] ca, input logic [8:0] vc, input logic fz);
    int n, r0, c0, d0, l0, s0, k0, dn0;
    refModel(int'(ca), int'(vc), fz);
    r0 = rjCnt; c0 = coCnt; d0 = daCnt; l0 = ldCnt; s0 = shCnt; k0 = clrCnt; dn0 = dnCnt;
    @(negedge Sclk);
    cur_addr = ca; valid_cnt = vc; flag_zero = fz; start = 1'b1;
    @(negedge Sclk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge Sclk);
      n++;
    end
    check({tag, "_latency"}, n, expL);
    check({tag, "_y"}, acc, expY);
    check({tag, "_rj_reads"}, rjCnt - r0, expRj);
    check({tag, "_coeff_reads"}, coCnt - c0, expCo);
    check({tag, "_data_reads"}, daCnt - d0, expData);
    check({tag, "_loads"}, ldCnt - l0, expData);
    check({tag, "_shifts"}, shCnt - s0, expShift);
    check({tag, "_acc_clears"}, clrCnt - k0, 1);
    check({tag, "_coeff_ovf"}, coeff_ovf, expOvf);
    if (expData > 0) begin
      check({tag, "_last_addr"}, lastAddr, expAddr);
      check({tag, "_last_sign"}, lastSign, expSign);
    end
    @(negedge Sclk);
    check({tag, "_done_pulses"}, dnCnt - dn0, 1);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int n, dn0;
    Reset_n = 1'b0; Clear = 1'b0; start = 1'b0; flag_zero = 1'b0;
    cur_addr = 8'h00; valid_cnt = 9'd0;
    for (int i = 0; i < 16; i++)  rjMem[i] = 16'h0000;
    for (int i = 0; i < 512; i++) coeffMem[i] = 16'h0000;
    for (int i = 0; i < 256; i++) dataMem[i] = 16'($urandom);
    repeat (3) @(negedge Sclk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {overrun, coeff_ovf}, 0);
    check("rst_strobes", {bus.rj_en, bus.coeff_en, bus.data_en, bus.load, bus.shift_en,
                          bus.adder_en, bus.addsub, bus.acc_clear}, 0);
    Reset_n = 1'b1;
    @(negedge Sclk);

    doConv("rj_zero", 8'h10, 9'd256, 1'b0);
    rjMem[0] = 16'd1; coeffMem[0] = 16'h0000;
    doConv("k0_add", 8'h05, 9'd6, 1'b0);
    coeffMem[0] = 16'h0103;
    doConv("wrap_sub", 8'h01, 9'd256, 1'b0);
    coeffMem[0] = 16'h000A;
    doConv("skip_term", 8'h20, 9'd4, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 16; j++) rjMem[j] = 16'($urandom_range(0, 4));
      for (int i = 0; i < 64; i++) coeffMem[i] = {7'b0, 1'($urandom_range(0, 1)), 8'($urandom)};
      for (int i = 0; i < 256; i++) dataMem[i] = 16'($urandom);
      doConv($sformatf("rand%0d", t), 8'($urandom), 9'($urandom_range(0, 256)), 1'b0);
    end

    for (int j = 0; j < 16; j++) rjMem[j] = 16'h0000;
    rjMem[0] = 16'd511; rjMem[1] = 16'd9;
    for (int i = 0; i < 512; i++) coeffMem[i] = {7'b0, 1'($urandom_range(0, 1)), 8'($urandom)};
    doConv("coeff_cap", 8'($urandom), 9'd256, 1'b0);

    // Overrun, then Clear while the accumulate step is active
    for (int j = 0; j < 16; j++) rjMem[j] = 16'h0000;
    rjMem[0] = 16'd1; coeffMem[0] = 16'h0000;
    cur_addr = 8'h05; valid_cnt = 9'd6;
    start = 1'b1; @(negedge Sclk); start = 1'b0;
    @(negedge Sclk);
    start = 1'b1; @(negedge Sclk); start = 1'b0;
    check("overrun_set", overrun, 1);
    n = 0;
    while (bus.load !== 1'b1 && n < 100) begin
      @(negedge Sclk);
      n++;
    end
    check("reach_acc", bus.load, 1);
    Clear = 1'b1;
    #1;
    check("clear_acc_clear", bus.acc_clear, 1);
    check("clear_no_load", bus.load, 0);
    dn0 = dnCnt;
    @(negedge Sclk);
    Clear = 1'b0;
    check("clear_idle", busy, 0);
    check("clear_overrun", overrun, 0);
    check("clear_coeff_ovf", coeff_ovf, 0);
    repeat (60) @(negedge Sclk);
    check("clear_no_done", dnCnt - dn0, 0);

    rjMem[0] = 16'd3; rjMem[5] = 16'd2;
    for (int i = 0; i < 8; i++) coeffMem[i] = {7'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 20))};
    doConv("flag_zero", 8'h33, 9'd100, 1'b1);

    // Asynchronous reset mid-computation
    start = 1'b1; @(negedge Sclk); start = 1'b0;
    repeat (4) @(negedge Sclk);
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_strobes", {bus.rj_en, bus.coeff_en, bus.data_en, bus.load, bus.shift_en}, 0);
    @(negedge Sclk);
    Reset_n = 1'b1;
    @(negedge Sclk);
    check("load_shift_exclusive", bothCnt, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
